// File: rtl/pwm_logger_pkg.sv
// Shared definitions for the PWM change logger peripheral:
// register map, control/status bit positions and event entry layout.
package pwm_logger_pkg;

    localparam int BUS_W   = 18;
    localparam int BOX_W   = 3;
    localparam int VAL_W   = 10;
    localparam int TIME_W  = 18;
    localparam int ENTRY_W = BOX_W + VAL_W + TIME_W;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_DATA = 2'd1;
    localparam logic [1:0] REG_TIME = 2'd2;
    localparam logic [1:0] REG_NOW  = 2'd3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;

    localparam int ST_OVF   = 17;
    localparam int ST_EN    = 16;
    localparam int ST_EMPTY = 15;

    typedef struct packed {
        logic [BOX_W-1:0]  box;
        logic [VAL_W-1:0]  value;
        logic [TIME_W-1:0] ts;
    } entry_t;

    // Bus view of an entry as returned by EVENT_DATA.
    function automatic logic [BUS_W-1:0] data_word(input entry_t e);
        return {e.box, 5'b0, e.value};
    endfunction

endpackage

// File: rtl/pwm_log_fifo.sv
// First-word-fall-through event FIFO with flush; DEPTH must be a power of 2
// so the read/write pointers wrap naturally.
module pwm_log_fifo #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = count_q[AW];
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/spmc_pwm_change_logger.sv
// SpartanMC peripheral that timestamps every change of the per-box PWM
// on-time values and queues the events for software to read.
module spmc_pwm_change_logger
    import pwm_logger_pkg::*;
#(
    parameter logic [9:0] BASE_ADR        = 10'h0,
    parameter int         NUMBER_OF_BOXES = 2,
    parameter int         PWM_REG_WIDTH   = 10,
    parameter int         FIFO_DEPTH      = 16,
    parameter int         TS_PRESCALE     = 16000
) (
    input  logic                                     clk_peri,
    input  logic                                     reset,
    input  logic [17:0]                              do_peri,
    output logic [17:0]                              di_peri,
    input  logic [9:0]                               addr_peri,
    input  logic                                     access_peri,
    input  logic                                     wr_peri,
    input  logic [PWM_REG_WIDTH*NUMBER_OF_BOXES-1:0] pwm_on_time,
    output logic                                     event_pending
);

    localparam int NB   = NUMBER_OF_BOXES;
    localparam int PW   = PWM_REG_WIDTH;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int PS_W = $clog2(TS_PRESCALE + 1);
    localparam logic [PS_W-1:0]   PS_LAST = PS_W'(TS_PRESCALE - 1);
    localparam logic [PS_W-1:0]   PS_ONE  = 1;
    localparam logic [TIME_W-1:0] TS_ONE  = 1;

    logic              en_q, en_d;
    logic              ovf_q, ovf_d;
    logic [NB-1:0]     pending_q, pending_d;
    logic [NB*PW-1:0]  prev_q;
    logic [PS_W-1:0]   ps_q, ps_d;
    logic [TIME_W-1:0] ts_q, ts_d;
    logic [BUS_W-1:0]  di_q, di_d;

    logic [9:0]        offset;
    logic              hit;
    logic [1:0]        reg_sel;
    logic              rd_en;
    logic              wr_en;
    logic              ctrl_wr;
    logic              now_wr;
    logic              clr;

    logic [NB-1:0]     chg;
    logic [NB-1:0]     grant;
    logic              req;
    logic [BOX_W-1:0]  sel_box;
    logic [VAL_W-1:0]  sel_val;

    entry_t            push_e;
    entry_t            head;
    logic [ENTRY_W-1:0] fifo_dout;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CW-1:0]     fifo_count;
    logic              push_ok;
    logic [BUS_W-1:0]  status;

    assign offset  = addr_peri - BASE_ADR;
    assign hit     = (offset[9:2] == '0);
    assign reg_sel = offset[1:0];
    assign rd_en   = access_peri && !wr_peri && hit;
    assign wr_en   = access_peri && wr_peri && hit;
    assign ctrl_wr = wr_en && (reg_sel == REG_CTRL);
    assign now_wr  = wr_en && (reg_sel == REG_NOW);
    assign clr     = ctrl_wr && do_peri[CTRL_CLR];

    always_comb begin
        chg = '0;
        for (int i = 0; i < NB; i++) begin
            chg[i] = en_q && (pwm_on_time[i*PW +: PW] != prev_q[i*PW +: PW]);
        end
    end

    // Descending scan so the lowest pending index wins.
    always_comb begin
        grant   = '0;
        req     = 1'b0;
        sel_box = '0;
        sel_val = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                grant   = '0;
                grant[i] = 1'b1;
                req     = 1'b1;
                sel_box = BOX_W'(i);
                sel_val = VAL_W'(pwm_on_time[i*PW +: PW]);
            end
        end
    end

    assign push_e.box   = sel_box;
    assign push_e.value = sel_val;
    assign push_e.ts    = ts_q;

    assign fifo_pop  = rd_en && (reg_sel == REG_DATA) && !fifo_empty;
    assign push_ok   = req && (!fifo_full || fifo_pop);
    assign fifo_push = push_ok && !clr;
    assign head      = entry_t'(fifo_dout);

    pwm_log_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_peri),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (clr),
        .din   (push_e),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_comb begin
        en_d      = ctrl_wr ? do_peri[CTRL_EN] : en_q;
        ovf_d     = ovf_q | (req && !push_ok);
        pending_d = (pending_q & ~grant) | chg;
        if (clr) begin
            ovf_d     = 1'b0;
            pending_d = '0;
        end
    end

    always_comb begin
        ps_d = ps_q + PS_ONE;
        ts_d = ts_q;
        if (now_wr) begin
            ps_d = '0;
            ts_d = do_peri;
        end else if (ps_q == PS_LAST) begin
            ps_d = '0;
            ts_d = ts_q + TS_ONE;
        end
    end

    always_comb begin
        status           = '0;
        status[ST_OVF]   = ovf_q;
        status[ST_EN]    = en_q;
        status[ST_EMPTY] = fifo_empty;
        status[7:0]      = 8'(fifo_count);
    end

    always_comb begin
        di_d = '0;
        if (rd_en) begin
            case (reg_sel)
                REG_CTRL: di_d = status;
                REG_DATA: di_d = fifo_empty ? '0 : data_word(head);
                REG_TIME: di_d = fifo_empty ? '0 : head.ts;
                default:  di_d = ts_q;
            endcase
        end
    end

    always_ff @(posedge clk_peri or posedge reset) begin
        if (reset) begin
            en_q      <= 1'b0;
            ovf_q     <= 1'b0;
            pending_q <= '0;
            prev_q    <= '0;
            ps_q      <= '0;
            ts_q      <= '0;
            di_q      <= '0;
        end else begin
            en_q      <= en_d;
            ovf_q     <= ovf_d;
            pending_q <= pending_d;
            prev_q    <= pwm_on_time;
            ps_q      <= ps_d;
            ts_q      <= ts_d;
            di_q      <= di_d;
        end
    end

    assign di_peri       = di_q;
    assign event_pending = !fifo_empty;

endmodule

// File: tb/tb_spmc_pwm_change_logger.sv
// Scoreboard bench for spmc_pwm_change_logger: bus reads queue their expected
// word, a monitor compares di_peri one cycle later.
module tb_spmc_pwm_change_logger;

    localparam int TSP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] do_peri;
    logic [17:0] di_peri;
    logic [9:0]  addr;
    logic        access;
    logic        wr;
    logic [19:0] pwm;
    logic        ev;

    int tests = 0;
    int fails = 0;

    logic [17:0] exp_q [$];
    string       name_q [$];
    logic        rd_seen;
    logic [17:0] mon_e;
    string       mon_n;

    logic [17:0] ts_m;
    int          ps_m;
    logic [17:0] t0, t1;

    always #5 clk = ~clk;

    spmc_pwm_change_logger #(
        .BASE_ADR        (10'h0),
        .NUMBER_OF_BOXES (2),
        .PWM_REG_WIDTH   (10),
        .FIFO_DEPTH      (16),
        .TS_PRESCALE     (TSP)
    ) dut (
        .clk_peri      (clk),
        .reset         (rst),
        .do_peri       (do_peri),
        .di_peri       (di_peri),
        .addr_peri     (addr),
        .access_peri   (access),
        .wr_peri       (wr),
        .pwm_on_time   (pwm),
        .event_pending (ev)
    );

    // Reference timestamp: prescaler of TSP cycles, loadable through TIME_NOW.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_m <= '0;
            ps_m <= 0;
        end else if (access && wr && addr == 10'd3) begin
            ts_m <= do_peri;
            ps_m <= 0;
        end else if (ps_m == TSP - 1) begin
            ps_m <= 0;
            ts_m <= ts_m + 18'd1;
        end else begin
            ps_m <= ps_m + 1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) rd_seen <= 1'b0;
        else     rd_seen <= access && !wr;
    end

    always @(negedge clk) begin
        if (rd_seen) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_read got=%h required=none", di_peri);
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                if (di_peri !== mon_e) begin
                    fails++;
                    $display("FAIL %s got=%h required=%h", mon_n, di_peri, mon_e);
                end
            end
        end else if (!rst) begin
            tests++;
            if (di_peri !== 18'd0) begin
                fails++;
                $display("FAIL idle_bus got=%h required=0", di_peri);
            end
        end
    end

    function automatic logic [17:0] st(input logic o, input logic e,
                                       input logic m, input int c);
        return {o, e, m, 7'b0, 8'(c)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s got=%0h required=%0h", n, got, req);
        end
    endtask

    task automatic bus_wr(input logic [9:0] a, input logic [17:0] d);
        addr = a; do_peri = d; wr = 1'b1; access = 1'b1;
        @(negedge clk);
        access = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [9:0] a, input logic [17:0] e,
                          input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        addr = a; wr = 1'b0; access = 1'b1;
        @(negedge clk);
        access = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; access = 1'b0; wr = 1'b0;
        addr = '0; do_peri = '0; pwm = '0;
        tick(3);
        rst = 1'b0;

        // reset state and a single event
        chk("rst_pending", 32'(ev), 32'd0);
        bus_rd(10'd0, st(0, 0, 1, 0), "status_reset");
        bus_rd(10'd3, ts_m, "now_after_reset");
        bus_wr(10'd0, 18'd1);
        pwm[9:0] = 10'd100;
        tick(1); t0 = ts_m; tick(1);
        chk("ev_after_push", 32'(ev), 32'd1);
        bus_rd(10'd0, st(0, 1, 0, 1), "status_one");
        bus_rd(10'd2, t0, "event_time_single");
        bus_rd(10'd1, 18'd100, "event_data_single");
        chk("ev_after_pop", 32'(ev), 32'd0);
        bus_rd(10'd0, st(0, 1, 1, 0), "status_after_pop");
        bus_rd(10'd1, 18'd0, "data_on_empty");

        // simultaneous change: box0 first, box1 a cycle later
        pwm = {10'd7, 10'd5};
        tick(1); t0 = ts_m; tick(1); t1 = ts_m;
        bus_rd(10'd0, st(0, 1, 0, 1), "status_mid_arb");
        bus_rd(10'd2, t0, "time_box0");
        bus_rd(10'd1, 18'd5, "data_box0");
        bus_rd(10'd2, t1, "time_box1");
        bus_rd(10'd1, 18'h08007, "data_box1");

        // box1 coalesced while box0 keeps the arbiter busy
        pwm = {10'd3, 10'd11}; tick(1);
        pwm = {10'd4, 10'd12}; tick(1);
        pwm = {10'd9, 10'd13}; tick(5);
        bus_rd(10'd0, st(0, 1, 0, 4), "coalesce_count");
        bus_rd(10'd1, 18'd12, "coalesce_b0_a");
        bus_rd(10'd1, 18'd13, "coalesce_b0_b");
        bus_rd(10'd1, 18'd13, "coalesce_b0_c");
        bus_rd(10'd1, 18'h08009, "coalesce_b1");
        bus_rd(10'd0, st(0, 1, 1, 0), "coalesce_empty");

        // overflow with 20 changes, then clear with enable kept
        for (int k = 0; k < 20; k++) begin
            pwm[9:0] = 10'(200 + k);
            tick(2);
        end
        bus_rd(10'd0, st(1, 1, 0, 16), "status_full");
        for (int k = 0; k < 16; k++) begin
            bus_rd(10'd1, 18'(200 + k), "full_data");
        end
        bus_rd(10'd0, st(1, 1, 1, 0), "ovf_sticky");
        pwm[9:0] = 10'd300; tick(2);
        pwm[9:0] = 10'd301; tick(2);
        chk("ev_before_clear", 32'(ev), 32'd1);
        bus_wr(10'd0, 18'd3);
        chk("ev_after_clear", 32'(ev), 32'd0);
        bus_rd(10'd0, st(0, 1, 1, 0), "status_clear");

        // changes while disabled leave no events behind
        bus_wr(10'd0, 18'd0);
        pwm[9:0] = 10'd10; tick(2);
        pwm[9:0] = 10'd20; tick(2);
        bus_wr(10'd0, 18'd1);
        tick(3);
        bus_rd(10'd0, st(0, 1, 1, 0), "no_stale_events");
        pwm[9:0] = 10'd30; tick(3);
        bus_rd(10'd0, st(0, 1, 0, 1), "enabled_count");
        bus_rd(10'd1, 18'd30, "enabled_data");

        // timestamp wrap through 2^18-1
        bus_wr(10'd3, 18'h3FFFE);
        bus_rd(10'd3, 18'h3FFFE, "now_preload_a");
        bus_rd(10'd3, 18'h3FFFE, "now_preload_b");
        bus_rd(10'd3, 18'h3FFFF, "now_max_a");
        bus_rd(10'd3, 18'h3FFFF, "now_max_b");
        pwm[9:0] = 10'd40;
        bus_rd(10'd3, 18'h00000, "now_wrapped");
        tick(2);
        bus_rd(10'd2, 18'd0, "wrap_event_time");
        bus_rd(10'd1, 18'd40, "wrap_event_data");

        // asynchronous reset with an entry queued
        pwm[9:0] = 10'd50; tick(3);
        chk("ev_before_reset", 32'(ev), 32'd1);
        #2 rst = 1'b1;
        #1 chk("ev_async_reset", 32'(ev), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus_rd(10'd0, st(0, 0, 1, 0), "status_post_reset");
        pwm[9:0] = 10'd60; tick(3);
        chk("ev_disabled_post_reset", 32'(ev), 32'd0);
        bus_wr(10'd0, 18'd1);
        pwm[9:0] = 10'd70; tick(3);
        bus_rd(10'd1, 18'd70, "first_post_reset");

        tick(3);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
